bit_entry: RTL and testbench

Player input stage for the flippy-bit game, sitting directly upstream of each falling-letter column. It debounces three raw DE0 push-buttons (cursor left, cursor right, flip) and maintains an 8-bit guess register and a 3-bit cursor. The guess register drives the column's `user_input` compare port. The column's `correct` output feeds back into `clear` to wipe the guess after a hit.

---
 rtl/bit_entry.sv | 132 +++++++++++++
 tb/tb_bit_entry.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_entry.sv
// bit_entry: debounced cursor/flip entry feeding one flippy-bit column.
// Define BIT_ENTRY_AUTO_REPEAT_EN to auto-repeat held cursor buttons.
module bit_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_left_n,
    input  logic       btn_right_n,
    input  logic       btn_flip_n,
    input  logic       clear,
    output logic [7:0] user_input,
    output logic [2:0] cursor,
    output logic       flip_strobe
);

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_F = 2;
    localparam logic [19:0] DB_LIMIT = 20'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= 2**20 ||
        REPEAT_CYCLES < 1 || REPEAT_CYCLES >= 2**24) begin : g_param_check
        $error("bit_entry: parameter out of range");
    end

    // Button vectors are active-low: bit value 1 means released.
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       level_q, level_d;
    logic [2:0][19:0] cnt_q, cnt_d;
    logic [2:0]       press;
    logic [7:0]       user_input_q, user_input_d;
    logic [2:0]       cursor_q, cursor_d;
    logic             flip_strobe_q, flip_strobe_d;
    logic             move_left, move_right;

`ifdef BIT_ENTRY_AUTO_REPEAT_EN
    localparam logic [23:0] REP_LIMIT = 24'(REPEAT_CYCLES);
    logic [23:0] rep_q, rep_d;
    logic        rep_fire;
`endif

    always_comb begin
        sync1_d = {btn_flip_n, btn_right_n, btn_left_n};
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        press   = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] + 20'd1 == DB_LIMIT) begin
                    cnt_d[i]   = '0;
                    level_d[i] = sync2_q[i];
                    press[i]   = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 20'd1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end

        move_left  = press[BTN_L];
        move_right = press[BTN_R];

`ifdef BIT_ENTRY_AUTO_REPEAT_EN
        // Repeat only while exactly one cursor button is held.
        rep_d    = '0;
        rep_fire = 1'b0;
        if (level_q[BTN_L] ^ level_q[BTN_R]) begin
            if (rep_q + 24'd1 == REP_LIMIT) begin
                rep_fire = 1'b1;
            end else begin
                rep_d = rep_q + 24'd1;
            end
        end
        if (rep_fire) begin
            move_left  = move_left | ~level_q[BTN_L];
            move_right = move_right | ~level_q[BTN_R];
        end
`endif

        cursor_d = cursor_q;
        case ({move_left, move_right})
            2'b10:   cursor_d = cursor_q + 3'd1;
            2'b01:   cursor_d = cursor_q - 3'd1;
            default: cursor_d = cursor_q;
        endcase

        user_input_d  = user_input_q;
        flip_strobe_d = 1'b0;
        if (clear) begin
            user_input_d = '0;
        end else if (press[BTN_F]) begin
            user_input_d[cursor_q] = ~user_input_q[cursor_q];
            flip_strobe_d          = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            level_q       <= '1;
            cnt_q         <= '0;
            user_input_q  <= '0;
            cursor_q      <= '0;
            flip_strobe_q <= 1'b0;
`ifdef BIT_ENTRY_AUTO_REPEAT_EN
            rep_q         <= '0;
`endif
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            level_q       <= level_d;
            cnt_q         <= cnt_d;
            user_input_q  <= user_input_d;
            cursor_q      <= cursor_d;
            flip_strobe_q <= flip_strobe_d;
`ifdef BIT_ENTRY_AUTO_REPEAT_EN
            rep_q         <= rep_d;
`endif
        end
    end

    assign user_input  = user_input_q;
    assign cursor      = cursor_q;
    assign flip_strobe = flip_strobe_q;

endmodule

// File: tb/tb_bit_entry.sv
// tb_bit_entry: scoreboard bench for bit_entry with a button-level model.
// Expected output events are queued by stimulus and popped by a monitor.
module tb_bit_entry;

    localparam int DB = 4;
    localparam int RP = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       btn_left_n;
    logic       btn_right_n;
    logic       btn_flip_n;
    logic       clear;
    logic [7:0] user_input;
    logic [2:0] cursor;
    logic       flip_strobe;

    int checks = 0;
    int failures = 0;

    logic [11:0] exp_q[$];
    logic [10:0] prev = '0;
    logic        mon_en = 1'b0;
    logic [11:0] obs;

    logic [7:0] m_ui;
    int         m_cur;

    bit_entry #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES  (RP)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .btn_left_n (btn_left_n),
        .btn_right_n(btn_right_n),
        .btn_flip_n (btn_flip_n),
        .clear      (clear),
        .user_input (user_input),
        .cursor     (cursor),
        .flip_strobe(flip_strobe)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: an output event is a strobe or any change of guess/cursor.
    always @(negedge clock) begin
        if (mon_en && reset_n) begin
            obs = {user_input, cursor, flip_strobe};
            if (flip_strobe || {user_input, cursor} != prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: got 0x%0h expected none", obs);
                end else begin
                    check("event", int'(obs), int'(exp_q.pop_front()));
                end
            end
            prev = {user_input, cursor};
        end
    end

    // Clean press of the chosen buttons together, held long enough to debounce.
    task automatic press(input bit l, input bit r, input bit f,
                         input int hold, input int gap);
        bit moved = 1'b0;
        if (f) m_ui[m_cur] = ~m_ui[m_cur];
        if (l && !r) begin
            m_cur = (m_cur + 1) % 8;
            moved = 1'b1;
        end else if (r && !l) begin
            m_cur = (m_cur + 7) % 8;
            moved = 1'b1;
        end
        if (f || moved) exp_q.push_back({m_ui, 3'(m_cur), f});
        btn_left_n  = !l;
        btn_right_n = !r;
        btn_flip_n  = !f;
        cyc(hold);
        btn_left_n  = 1'b1;
        btn_right_n = 1'b1;
        btn_flip_n  = 1'b1;
        cyc(gap);
    endtask

    task automatic do_clear(input int len, input int gap);
        if (m_ui != 8'h00) exp_q.push_back({8'h00, 3'(m_cur), 1'b0});
        m_ui  = 8'h00;
        clear = 1'b1;
        cyc(len);
        clear = 1'b0;
        cyc(gap);
    endtask

    initial begin
        int n_moves;
        int kind;
        int hold;
        int gap;

        reset_n     = 1'b0;
        btn_left_n  = 1'b0;
        btn_right_n = 1'b0;
        btn_flip_n  = 1'b0;
        clear       = 1'b0;
        m_ui        = 8'h00;
        m_cur       = 0;
        cyc(3);
        check("reset_user_input", int'(user_input), 0);
        check("reset_cursor", int'(cursor), 0);
        check("reset_strobe", int'(flip_strobe), 0);

        // All buttons still held: left/right cancel, flip toggles bit 0.
        reset_n = 1'b1;
        mon_en  = 1'b1;
        m_ui    = 8'h01;
        exp_q.push_back({8'h01, 3'd0, 1'b1});
        cyc(5);
        check("reset_no_early_action", int'(user_input), 0);
        cyc(1);
        check("reset_first_action", int'(user_input), 1);
        btn_left_n  = 1'b1;
        btn_right_n = 1'b1;
        btn_flip_n  = 1'b1;
        cyc(8);
        do_clear(1, 6);

        // Flip latency and single-cycle strobe.
        m_ui = 8'h01;
        exp_q.push_back({8'h01, 3'd0, 1'b1});
        btn_flip_n = 1'b0;
        cyc(5);
        check("flip_not_early", int'(user_input), 0);
        cyc(1);
        check("flip_applied", int'(user_input), 1);
        check("flip_strobe_high", int'(flip_strobe), 1);
        cyc(1);
        check("flip_strobe_one_cycle", int'(flip_strobe), 0);
        cyc(5);
        btn_flip_n = 1'b1;
        cyc(10);
        check("flip_release_no_change", int'(user_input), 1);
        do_clear(2, 6);

        // Bounce shorter than the debounce window.
        btn_flip_n = 1'b0;
        cyc(3);
        btn_flip_n = 1'b1;
        cyc(1);
        btn_flip_n = 1'b0;
        cyc(3);
        btn_flip_n = 1'b1;
        cyc(10);
        check("bounce_rejected", int'(user_input), 0);

        // Cursor moves and wrap.
        repeat (3) press(1, 0, 0, 6, 6);
        check("cursor_left3", int'(cursor), 3);
        press(0, 0, 1, 6, 6);
        check("flip_at_3", int'(user_input), 8'h08);
        repeat (4) press(0, 1, 0, 6, 6);
        check("cursor_wrap_7", int'(cursor), 7);
        press(0, 0, 1, 6, 6);
        check("flip_at_7", int'(user_input), 8'h88);

        // Clear on the same edge a flip is accepted.
        m_ui = 8'h00;
        exp_q.push_back({8'h00, 3'd7, 1'b0});
        btn_flip_n = 1'b0;
        cyc(5);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(3);
        btn_flip_n = 1'b1;
        cyc(8);
        check("clear_priority_ui", int'(user_input), 0);
        check("clear_priority_cursor", int'(cursor), 7);

        // Held left button for 25 cycles beyond its press edge.
        press(1, 0, 0, 5, 8);
        n_moves = 1;
`ifdef BIT_ENTRY_AUTO_REPEAT_EN
        n_moves = n_moves + 25 / RP;
`endif
        for (int k = 0; k < n_moves; k++) begin
            m_cur = (m_cur + 1) % 8;
            exp_q.push_back({m_ui, 3'(m_cur), 1'b0});
        end
        btn_left_n = 1'b0;
        cyc(25);
        btn_left_n = 1'b1;
        cyc(12);
        check("auto_repeat_cursor", int'(cursor), m_cur);

        // Random clean presses and clears.
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 6);
            hold = $urandom_range(5, 7);
            gap  = $urandom_range(5, 8);
            case (kind)
                0: press(1, 0, 0, hold, gap);
                1: press(0, 1, 0, hold, gap);
                2: press(0, 0, 1, hold, gap);
                3: press(1, 1, 0, hold, gap);
                4: press(1, 0, 1, hold, gap);
                5: press(0, 1, 1, hold, gap);
                default: do_clear($urandom_range(1, 3), gap);
            endcase
        end

        cyc(20);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: got %0d left expected 0", exp_q.size());
        end
        check("final_user_input", int'(user_input), int'(m_ui));
        check("final_cursor", int'(cursor), m_cur);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
